m_lsu_req: RTL and testbench
============================

Name: m_lsu_req

Overview:
- Initiator side of the M-stage data-memory interface: pipeline issues a load/store; block aligns it, drives a req/gnt/rvalid handshake to a variable-latency word memory, extends load data and stalls the pipeline until done.
- Sits between the M-stage datapath and data memory; performs the sub-word alignment (byte/half placement, sign/zero extension) the memory no longer does.

Parameters:
- ADDR_W, 32, byte-address width
- MEM_WORDS, 3072, memory depth in words; addresses at/above MEM_WORDS*4 flag an access error

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pc  in  32  PC of the requesting instruction (trace only)
- req_valid  in  1  pipeline request; held until resp_valid
- req_we  in  1  1=store, 0=load
- req_op  in  3  0=w, 1=h, 2=hu, 3=b, 4=bu; 5-7 illegal
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-justified
- stall  out  1  pipeline hold
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data
- resp_err  out  1  misaligned/out-of-range/illegal op, valid with resp_valid
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  word-aligned address (addr[1:0]=0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-shifted store data
- mem_gnt  in  1  memory accepts request
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  raw read word

Behaviour:
- All outputs registered. Reset (async, any state, mid-transaction included): state IDLE; all outputs 0 immediately. The outstanding memory transaction is abandoned; any later mem_gnt/mem_rvalid is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - stall = req_valid (combinational OR with the busy flag).
  - On req_valid, latch op, we, addr, wdata, pc.
  - If the error check fails: go DONE with resp_err=1 and no memory access.
  - Otherwise go REQ, with mem_req=1 next cycle.
- Error check:
  - op w requires addr[1:0]=0.
  - op h/hu requires addr[0]=0.
  - addr >= MEM_WORDS*4 is an error.
  - op 5-7 is an error.
- mem_be:
  - w: 4'b1111
  - h/hu: 4'b0011 << (2*addr[1])
  - b/bu: 4'b0001 << addr[1:0]
- Lane placement: mem_wdata = wdata replicated across lanes (byte x4, half x2, word as-is).
- Loads drive mem_be the same way; the memory ignores mem_be on reads.
- REQ:
  - mem_req/mem_we/mem_addr/mem_be/mem_wdata held stable until mem_gnt.
  - On gnt with a store: mem_req drops next cycle; go DONE.
  - On gnt with a load: go WAIT, or go directly to DONE if mem_rvalid is also high in the same cycle.
  - No timeout.
- WAIT:
  - On mem_rvalid, capture mem_rdata and go DONE.
  - Extraction selects the byte (addr[1:0]) or half (addr[1]); b/h sign-extend, bu/hu zero-extend, w passes through.
- DONE:
  - resp_valid=1 for one cycle; stall=0 this cycle; return to IDLE.
  - resp_rdata = extracted value for loads, 0 for stores and errors.
  - resp_rdata and resp_err hold until the next request completes.
- Back-to-back: a new request may be latched in the cycle after DONE. Minimum occupancy is 3 cycles per access (IDLE→REQ→DONE) with gnt in the first REQ cycle.
- Stray mem_gnt/mem_rvalid in IDLE/DONE: ignored.

Optional Feature:
- Macro LSU_STORE_TRACE_EN.
- Defined: on each granted store, $display("%d@%h: *%h <= %h", $time, pc, addr, merged_word).
  - addr is the original byte address.
  - merged_word is the previous word contents with the new lanes substituted.
  - Previous contents come from a shadow copy kept by a MEM_WORDS-deep internal register array, updated on granted stores and cleared on reset.
- Undefined: no shadow array, no display; behaviour otherwise identical.

Test Plan:
- Store w addr=0x10 wdata=0xDEADBEEF, gnt after 2 cycles → mem_addr=0x10, be=1111, wdata=0xDEADBEEF, resp_valid 4 cycles after req, err=0.
- Store b addr=0x13 wdata=0x000000AB → be=1000, mem_wdata=0xABABABAB, mem_addr=0x10.
- Load b addr=0x12, mem_rdata=0x1280FF00, rvalid 3 cycles after gnt → resp_rdata=0xFFFFFF80. Same with bu → 0x00000080. h at 0x12 → 0x00001280.
- Load w addr=0x06 → resp_err=1 one cycle after req, mem_req never asserted. Addr 0x3000 with op b → also err.
- Load with gnt and rvalid in the same cycle, mem_rdata=0x7FFF0000, op hu addr=0x2 → resp_rdata=0x00007FFF, no WAIT cycle.
- Assert reset while in WAIT → mem_req/stall/resp_valid 0 immediately. A later mem_rvalid pulse produces no resp_valid. The next request then completes normally.

Source files
------------

// File: rtl/m_lsu_req_if.sv
// m_lsu_req_if: word-memory request/grant/rvalid bus.
// master = load/store initiator, slave = memory.
interface m_lsu_req_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/m_lsu_req.sv
// m_lsu_req: M-stage load/store initiator with sub-word alignment.
// Optional store trace with shadow memory: define LSU_STORE_TRACE_EN.
module m_lsu_req #(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 3072
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  m_lsu_req_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] LIMIT =
    (ADDR_W+1)'(MEM_WORDS * 4);

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              we_q, we_d;
  logic [1:0]        off_q, off_d;
  logic              busy_q, busy_d;
  logic              mreq_q, mreq_d;
  logic              mwe_q, mwe_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [3:0]        mbe_q, mbe_d;
  logic [31:0]       mwdata_q, mwdata_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              is_w, is_h, is_b;
  logic [3:0]        be_c;
  logic [31:0]       wd_c;
  logic              err_c;
  logic [31:0]       ext_c;

  function automatic logic [31:0] extract(
    input logic [2:0]  op,
    input logic [1:0]  off,
    input logic [31:0] d
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (off)
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    unique case (op)
      3'd1: r = {{16{h[15]}}, h};
      3'd2: r = {16'h0, h};
      3'd3: r = {{24{b[7]}}, b};
      3'd4: r = {24'h0, b};
      default: r = d;
    endcase
    return r;
  endfunction

  // Decode of the incoming request, used only while IDLE.
  always_comb begin
    is_w  = req_op == 3'd0;
    is_h  = req_op == 3'd1 || req_op == 3'd2;
    is_b  = req_op == 3'd3 || req_op == 3'd4;
    be_c  = 4'b0000;
    wd_c  = req_wdata;
    err_c = {1'b0, req_addr} >= LIMIT;
    unique case (1'b1)
      is_w: begin
        be_c  = 4'b1111;
        err_c = err_c | (req_addr[1:0] != 2'b00);
      end
      is_h: begin
        be_c  = req_addr[1] ? 4'b1100 : 4'b0011;
        wd_c  = {2{req_wdata[15:0]}};
        err_c = err_c | req_addr[0];
      end
      is_b: begin
        be_c = 4'b0001 << req_addr[1:0];
        wd_c = {4{req_wdata[7:0]}};
      end
      default: err_c = 1'b1;
    endcase
  end

  assign ext_c = extract(op_q, off_q, bus.mem_rdata);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    we_d     = we_q;
    off_d    = off_q;
    busy_d   = busy_q;
    mreq_d   = mreq_q;
    mwe_d    = mwe_q;
    maddr_d  = maddr_q;
    mbe_d    = mbe_q;
    mwdata_d = mwdata_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          we_d  = req_we;
          off_d = req_addr[1:0];
          if (err_c) begin
            state_d  = DONE;
            rvalid_d = 1'b1;
            rdata_d  = '0;
            err_d    = 1'b1;
          end else begin
            state_d  = REQ;
            busy_d   = 1'b1;
            mreq_d   = 1'b1;
            mwe_d    = req_we;
            maddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            mbe_d    = be_c;
            mwdata_d = wd_c;
          end
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          mreq_d = 1'b0;
          if (we_q || bus.mem_rvalid) begin
            state_d  = DONE;
            busy_d   = 1'b0;
            rvalid_d = 1'b1;
            rdata_d  = we_q ? '0 : ext_c;
            err_d    = 1'b0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          state_d  = DONE;
          busy_d   = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = ext_c;
          err_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      we_q     <= 1'b0;
      off_q    <= '0;
      busy_q   <= 1'b0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mbe_q    <= '0;
      mwdata_q <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      we_q     <= we_d;
      off_q    <= off_d;
      busy_q   <= busy_d;
      mreq_q   <= mreq_d;
      mwe_q    <= mwe_d;
      maddr_q  <= maddr_d;
      mbe_q    <= mbe_d;
      mwdata_q <= mwdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Gated by reset so the pipeline is released the instant reset hits.
  assign stall = ~reset &
    (busy_q | (state_q == IDLE && req_valid));

  assign resp_valid    = rvalid_q;
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign bus.mem_req   = mreq_q;
  assign bus.mem_we    = mwe_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_be    = mbe_q;
  assign bus.mem_wdata = mwdata_q;

`ifdef LSU_STORE_TRACE_EN
  localparam int IW = $clog2(MEM_WORDS);

  logic [31:0]       shadow [MEM_WORDS];
  logic [31:0]       pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       merged;
  logic [IW-1:0]     widx;
  logic              st_fire;

  assign widx    = addr_q[IW+1:2];
  assign st_fire = state_q == REQ && we_q && bus.mem_gnt;

  always_comb begin
    merged = shadow[widx];
    for (int i = 0; i < 4; i++)
      if (mbe_q[i]) merged[8*i +: 8] = mwdata_q[8*i +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= '0;
      addr_q <= '0;
      for (int i = 0; i < MEM_WORDS; i++)
        shadow[i] <= '0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        pc_q   <= pc;
        addr_q <= req_addr;
      end
      if (st_fire) begin
        shadow[widx] <= merged;
        $display("%d@%h: *%h <= %h",
                 $time, pc_q, addr_q, merged);
      end
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_m_lsu_req.sv
// tb_m_lsu_req: directed load/store vectors with a
// response and memory-request scoreboard.
module tb_m_lsu_req;

  localparam logic [31:0] JUNK = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    int          id;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mreq_t;

  resp_t rq[$];
  mreq_t mq[$];

  m_lsu_req_if #(.ADDR_W(32)) bus ();

  m_lsu_req #(
    .ADDR_W(32),
    .MEM_WORDS(3072)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pc(pc),
    .req_valid(req_valid),
    .req_we(req_we),
    .req_op(req_op),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .stall(stall),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h",
               name, act, exp);
    end
  endtask

  // Monitor: responses and granted memory requests.
  always @(negedge clk) begin
    resp_t r;
    mreq_t m;
    if (!reset && resp_valid) begin
      resp_cnt++;
      if (rq.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        r = rq.pop_front();
        chk($sformatf("v%0d_err", r.id),
            {31'd0, resp_err}, {31'd0, r.err});
        chk($sformatf("v%0d_rdata", r.id),
            resp_rdata, r.rdata);
      end
    end
    if (!reset && bus.mem_req && bus.mem_gnt) begin
      if (mq.size() == 0) begin
        chk("unexpected_gnt", 32'd1, 32'd0);
      end else begin
        m = mq.pop_front();
        chk($sformatf("v%0d_mem_we", m.id),
            {31'd0, bus.mem_we}, {31'd0, m.we});
        chk($sformatf("v%0d_mem_addr", m.id),
            bus.mem_addr, m.addr);
        chk($sformatf("v%0d_mem_be", m.id),
            {28'd0, bus.mem_be}, {28'd0, m.be});
        chk($sformatf("v%0d_mem_wdata", m.id),
            bus.mem_wdata, m.wdata);
      end
    end
  end

  task automatic access(
    input int          id,
    input logic        we,
    input logic [2:0]  op,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input int          gdly,
    input int          rdly,
    input logic [31:0] rd,
    input logic        eerr,
    input logic [31:0] erd,
    input logic [3:0]  ebe,
    input logic [31:0] ewd,
    input int          elat
  );
    int gc, gn;
    bit granted, rdone, done;
    bit saw_req, stall_ok;
    rq.push_back('{id, eerr, erd});
    if (!eerr)
      mq.push_back('{id, we, addr & 32'hFFFF_FFFC, ebe, ewd});
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    pc        = 32'h1000 + 32'(id * 4);
    #1;
    chk($sformatf("v%0d_stall_req", id),
        {31'd0, stall}, 32'd1);
    gc = 0; gn = 0;
    granted = 0; rdone = 0; done = 0;
    saw_req = 0; stall_ok = 1;
    for (int n = 1; n <= 60 && !done; n++) begin
      @(posedge clk);
      #1;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = JUNK;
      if (resp_valid) begin
        done = 1;
        chk($sformatf("v%0d_latency", id),
            32'(n), 32'(elat));
        chk($sformatf("v%0d_stall_done", id),
            {31'd0, stall}, 32'd0);
      end else begin
        if (!stall) stall_ok = 0;
        if (bus.mem_req) saw_req = 1;
        if (!granted && bus.mem_req) begin
          if (gc == gdly) begin
            bus.mem_gnt = 1'b1;
            granted = 1;
            gn = n;
            if (!we && rdly == 0) begin
              bus.mem_rvalid = 1'b1;
              bus.mem_rdata  = rd;
              rdone = 1;
            end
          end
          gc++;
        end else if (granted && !we && !rdone &&
                     n == gn + rdly) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = rd;
          rdone = 1;
        end
      end
    end
    if (!done)
      chk($sformatf("v%0d_timeout", id), 32'd1, 32'd0);
    chk($sformatf("v%0d_memreq_seen", id),
        {31'd0, saw_req}, {31'd0, ~eerr});
    chk($sformatf("v%0d_stall_busy", id),
        {31'd0, stall_ok}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  initial begin
    int rc;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = JUNK;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // id we op addr wdata gdly rdly rdata err erd be ewd lat
    access(1, 1, 3'd0, 32'h10, 32'hDEADBEEF, 2, 0, 0,
           0, 0, 4'b1111, 32'hDEADBEEF, 4);
    access(2, 1, 3'd3, 32'h13, 32'h000000AB, 0, 0, 0,
           0, 0, 4'b1000, 32'hABABABAB, 2);
    access(3, 1, 3'd1, 32'h16, 32'h00001234, 1, 0, 0,
           0, 0, 4'b1100, 32'h12341234, 3);
    access(4, 0, 3'd3, 32'h12, 0, 0, 3, 32'h1280FF00,
           0, 32'hFFFFFF80, 4'b0100, 0, 5);
    access(5, 0, 3'd4, 32'h12, 0, 0, 3, 32'h1280FF00,
           0, 32'h00000080, 4'b0100, 0, 5);
    access(6, 0, 3'd1, 32'h12, 0, 0, 3, 32'h1280FF00,
           0, 32'h00001280, 4'b1100, 0, 5);
    access(7, 0, 3'd1, 32'h10, 0, 1, 1, 32'h1280FF00,
           0, 32'hFFFFFF00, 4'b0011, 0, 4);
    access(8, 0, 3'd0, 32'h08, 0, 0, 2, 32'h89ABCDEF,
           0, 32'h89ABCDEF, 4'b1111, 0, 4);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_rdata", resp_rdata, 32'h89ABCDEF);
    access(9, 0, 3'd0, 32'h06, 0, 0, 0, 0,
           1, 0, 0, 0, 1);
    access(10, 0, 3'd3, 32'h3000, 0, 0, 0, 0,
           1, 0, 0, 0, 1);
    access(11, 0, 3'd2, 32'h02, 0, 0, 0, 32'h7FFF0000,
           0, 32'h00007FFF, 4'b1100, 0, 2);
    access(12, 1, 3'd5, 32'h00, 32'h1, 0, 0, 0,
           1, 0, 0, 0, 1);
    access(13, 0, 3'd1, 32'h01, 0, 0, 0, 0,
           1, 0, 0, 0, 1);
    access(14, 0, 3'd3, 32'h2FFF, 0, 0, 1, 32'h5A000000,
           0, 32'h0000005A, 4'b1000, 0, 3);
    access(15, 1, 3'd0, 32'h2FFC, 32'h01020304, 0, 0, 0,
           0, 0, 4'b1111, 32'h01020304, 2);
    access(16, 0, 3'd3, 32'h01, 0, 0, 1, 32'h0000C300,
           0, 32'hFFFFFFC3, 4'b0010, 0, 3);

    // Reset while waiting for read data.
    mq.push_back('{99, 1'b0, 32'h20, 4'b1111, 32'h0});
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_op    = 3'd0;
    req_addr  = 32'h20;
    req_wdata = 32'h0;
    @(posedge clk);
    #1;
    chk("rw_mem_req", {31'd0, bus.mem_req}, 32'd1);
    bus.mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_gnt = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rw_mem_req_rst", {31'd0, bus.mem_req}, 32'd0);
    chk("rw_stall_rst", {31'd0, stall}, 32'd0);
    chk("rw_resp_valid_rst", {31'd0, resp_valid}, 32'd0);
    chk("rw_resp_rdata_rst", resp_rdata, 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rc = resp_cnt;
    @(posedge clk);
    #1;
    bus.mem_rvalid = 1'b1;
    bus.mem_gnt    = 1'b1;
    bus.mem_rdata  = 32'h11111111;
    @(posedge clk);
    #1;
    bus.mem_rvalid = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rdata  = JUNK;
    repeat (3) @(posedge clk);
    #1;
    chk("rw_no_stray_resp", 32'(resp_cnt), 32'(rc));
    chk("rw_idle_mem_req", {31'd0, bus.mem_req}, 32'd0);

    access(17, 0, 3'd0, 32'h20, 0, 0, 1, 32'h13579BDF,
           0, 32'h13579BDF, 4'b1111, 0, 3);

    repeat (2) @(posedge clk);
    #1;
    chk("resp_queue_empty", 32'(rq.size()), 32'd0);
    chk("mreq_queue_empty", 32'(mq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
